// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - shared types and helpers for the arbitrated ROM
package rom_pkg;

  localparam int MAX_CHANNELS = 16;
  localparam int CHAN_TAG_W   = 4;

  // Response tag travels beside the read data through every pipeline stage.
  typedef struct packed {
    logic [CHAN_TAG_W-1:0] chan;
    logic                  oob;
  } rsp_tag_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rom_arb_sync_rr_arbiter.sv
// rtl/rom_arb_sync_rr_arbiter.sv - round-robin arbiter owning the priority pointer
module rr_arbiter
  import rom_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] r_ptr;
  logic          w_found;

  // Lowest requester overall is the wrap-around fallback; a requester at or
  // above the pointer overrides it, giving the ptr, ptr+1, ... search order.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    for (int c = N - 1; c >= 0; c--) begin
      if (req[c]) begin
        idx     = IW'(c);
        w_found = 1'b1;
      end
    end
    for (int c = N - 1; c >= 0; c--) begin
      if (req[c] && (c >= int'(r_ptr))) begin
        idx = IW'(c);
      end
    end
    if (w_found) begin
      gnt = N'(1) << idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (en && w_found) begin
      r_ptr <= (int'(idx) == N - 1) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/rom_arb_sync.sv
// rtl/rom_arb_sync.sv - single-port synchronous ROM shared by round-robin read clients
module rom_arb_sync
  import rom_pkg::*;
#(
  parameter int  WIDTH    = 8,
  parameter int  DEPTH    = 256,
  parameter int  CHANNELS = 4,
  parameter      INIT_F   = "",
  parameter int  OUT_REG  = 1,
  localparam int ADDRW    = clog2_min1(DEPTH),
  localparam int CW       = clog2_min1(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       req_valid,
  input  logic [CHANNELS*ADDRW-1:0] req_addr,
  output logic [CHANNELS-1:0]       req_ready,
  output logic                      rsp_valid,
  output logic [CW-1:0]             rsp_chan,
  output logic [WIDTH-1:0]          rsp_data,
  output logic                      rsp_oob
);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  logic [CHANNELS-1:0] w_gnt;
  logic [CW-1:0]       w_idx;
  logic                w_accept;
  logic [ADDRW-1:0]    w_addr;
  logic                w_oob;
  rsp_tag_t            w_tag0;

  rr_arbiter #(.N(CHANNELS)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (w_accept),
    .gnt   (w_gnt),
    .idx   (w_idx)
  );

  assign req_ready = w_gnt;
  assign w_accept  = |(req_valid & w_gnt);
  assign w_addr    = req_addr[w_idx*ADDRW +: ADDRW];
  assign w_oob     = 32'(w_addr) >= 32'(DEPTH);

  always_comb begin
    w_tag0      = '0;
    w_tag0.chan = CHAN_TAG_W'(w_idx);
    w_tag0.oob  = w_oob;
  end

  // Array read stays reset-free so it maps onto block RAM.
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (w_accept && !w_oob) begin
      r_rdata <= r_mem[w_addr];
    end
  end

  logic             r_v1;
  logic             r_live1;
  rsp_tag_t         r_tag1;
  logic [WIDTH-1:0] w_data1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_live1 <= 1'b0;
      r_tag1  <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_tag1  <= w_tag0;
        r_live1 <= 1'b1;
      end
    end
  end

  // r_live1 masks the unreset RAM latch until a real request has landed.
  assign w_data1 = (r_live1 && !r_tag1.oob) ? r_rdata : '0;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic             r_v2;
      rsp_tag_t         r_tag2;
      logic [WIDTH-1:0] r_d2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v2   <= 1'b0;
          r_tag2 <= '0;
          r_d2   <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_tag2 <= r_tag1;
            r_d2   <= w_data1;
          end
        end
      end

      assign rsp_valid = r_v2;
      assign rsp_chan  = r_tag2.chan[CW-1:0];
      assign rsp_oob   = r_tag2.oob;
      assign rsp_data  = r_d2;
    end else begin : g_no_out_reg
      assign rsp_valid = r_v1;
      assign rsp_chan  = r_tag1.chan[CW-1:0];
      assign rsp_oob   = r_tag1.oob;
      assign rsp_data  = w_data1;
    end
  endgenerate

endmodule

// File: tb/tb_rom_arb_sync.sv
// tb/tb_rom_arb_sync.sv - directed self-checking bench for rom_arb_sync
module tb_rom_arb_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_chan;
  logic [7:0]  rsp_data;
  logic        rsp_oob;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rom_arb_sync #(
    .WIDTH    (8),
    .DEPTH    (200),
    .CHANNELS (4),
    .INIT_F   (""),
    .OUT_REG  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_chan  (rsp_chan),
    .rsp_data  (rsp_data),
    .rsp_oob   (rsp_oob)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int ch, input logic [7:0] a);
    req_addr[ch*8 +: 8] = a;
  endtask

  initial begin
    for (int i = 0; i < 200; i++) begin
      dut.r_mem[i] = 8'(i);
    end
  end

  initial begin
    req_valid = '0;
    req_addr  = '0;

    repeat (3) step();
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_chan",  32'(rsp_chan),  0);
    check("rst_data",  32'(rsp_data),  0);
    check("rst_oob",   32'(rsp_oob),   0);
    check("rst_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_quiet", 32'(rsp_valid), 0);
    end

    for (int k = 0; k < 4; k++) set_addr(k, 8'(8'h20 + k));
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        req_valid = 4'hf;
        #1;
        check("fair_gnt", 32'(req_ready), 32'(1 << (i % 4)));
      end else begin
        req_valid = 4'h0;
      end
      if (i >= 2) begin
        check("fair_rsp_valid", 32'(rsp_valid), 1);
        check("fair_rsp_chan",  32'(rsp_chan),  32'((i - 2) % 4));
        check("fair_rsp_data",  32'(rsp_data),  32'(8'h20 + (i - 2) % 4));
      end
      step();
    end
    check("fair_idle", 32'(rsp_valid), 0);

    set_addr(2, 8'h10);
    req_valid = 4'b0100;
    #1;
    check("single_gnt", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0000;
    check("single_lat1", 32'(rsp_valid), 0);
    step();
    check("single_valid", 32'(rsp_valid), 1);
    check("single_chan",  32'(rsp_chan),  2);
    check("single_data",  32'(rsp_data),  32'h10);
    check("single_oob",   32'(rsp_oob),   0);
    step();

    set_addr(3, 8'h33);
    set_addr(1, 8'h11);
    req_valid = 4'b1010;
    #1;
    check("wrap_gnt3", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b0010;
    #1;
    check("wrap_gnt1", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0000;
    check("wrap_rsp3_valid", 32'(rsp_valid), 1);
    check("wrap_rsp3_chan",  32'(rsp_chan),  3);
    check("wrap_rsp3_data",  32'(rsp_data),  32'h33);
    step();
    check("wrap_rsp1_valid", 32'(rsp_valid), 1);
    check("wrap_rsp1_chan",  32'(rsp_chan),  1);
    check("wrap_rsp1_data",  32'(rsp_data),  32'h11);
    req_valid = 4'hf;
    #1;
    check("wrap_ptr2", 32'(req_ready), 32'h4);
    req_valid = 4'h0;
    step();

    set_addr(0, 8'd201);
    req_valid = 4'b0001;
    #1;
    check("oob_gnt", 32'(req_ready), 32'h1);
    step();
    set_addr(0, 8'd199);
    step();
    req_valid = 4'b0000;
    check("oob_valid", 32'(rsp_valid), 1);
    check("oob_flag",  32'(rsp_oob),   1);
    check("oob_data",  32'(rsp_data),  0);
    check("oob_chan",  32'(rsp_chan),  0);
    step();
    check("last_valid", 32'(rsp_valid), 1);
    check("last_oob",   32'(rsp_oob),   0);
    check("last_data",  32'(rsp_data),  32'd199);
    step();
    check("hold_valid", 32'(rsp_valid), 0);
    check("hold_data",  32'(rsp_data),  32'd199);
    check("hold_oob",   32'(rsp_oob),   0);

    set_addr(1, 8'd5);
    req_valid = 4'b0010;
    step();
    set_addr(2, 8'd6);
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    check("mid_inflight", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_data",  32'(rsp_data),  0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_quiet", 32'(rsp_valid), 0);
    end
    set_addr(3, 8'd7);
    req_valid = 4'b1000;
    #1;
    check("mid_gnt", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b0000;
    step();
    check("mid_rsp_valid", 32'(rsp_valid), 1);
    check("mid_rsp_chan",  32'(rsp_chan),  3);
    check("mid_rsp_data",  32'(rsp_data),  7);
    check("mid_rsp_oob",   32'(rsp_oob),   0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
